// File: rtl/polybius_decrypt.sv
// Nihilist decryptor over the "DANIEL" keyed 5x5 Polybius square, all characters decoded in parallel.
// Latency: 1 cycle from i_w_valid to o_r_valid; one result per cycle when i_w_valid is held.
// Backpressure: none; the consumer must accept every o_r_valid pulse, and text holds between captures.
module polybius_decrypt #(
    parameter int p_cipher_length = 27,
    parameter int p_secret_length = 6
) (
    input  logic                         i_w_clk,
    input  logic                         i_w_rst_n,
    input  logic                         i_w_valid,
    input  logic [p_cipher_length*8-1:0] i_w_cipher,
    input  logic [p_secret_length*8-1:0] i_w_secret,
    output logic [p_cipher_length*8-1:0] o_r_text,
    output logic                         o_r_valid
);

    // Square code of an uppercase key letter; 0 flags a non-letter key byte.
    function automatic logic [7:0] f_key_code(input logic [7:0] i_ch);
        logic [7:0] v_code;
        v_code = 8'd0;
        case (i_ch)
            "D": v_code = 8'd11;
            "A": v_code = 8'd12;
            "N": v_code = 8'd13;
            "I": v_code = 8'd14;
            "J": v_code = 8'd14;
            "E": v_code = 8'd15;
            "L": v_code = 8'd21;
            "B": v_code = 8'd22;
            "C": v_code = 8'd23;
            "F": v_code = 8'd24;
            "G": v_code = 8'd25;
            "H": v_code = 8'd31;
            "K": v_code = 8'd32;
            "M": v_code = 8'd33;
            "O": v_code = 8'd34;
            "P": v_code = 8'd35;
            "Q": v_code = 8'd41;
            "R": v_code = 8'd42;
            "S": v_code = 8'd43;
            "T": v_code = 8'd44;
            "U": v_code = 8'd45;
            "V": v_code = 8'd51;
            "W": v_code = 8'd52;
            "X": v_code = 8'd53;
            "Y": v_code = 8'd54;
            "Z": v_code = 8'd55;
            default: v_code = 8'd0;
        endcase
        return v_code;
    endfunction

    // Any code outside the 25 valid row/column pairs decodes to '?'.
    function automatic logic [7:0] f_symbol(input logic [7:0] i_code);
        logic [7:0] v_ch;
        v_ch = 8'h3F;
        case (i_code)
            8'd11: v_ch = "D";
            8'd12: v_ch = "A";
            8'd13: v_ch = "N";
            8'd14: v_ch = "I";
            8'd15: v_ch = "E";
            8'd21: v_ch = "L";
            8'd22: v_ch = "B";
            8'd23: v_ch = "C";
            8'd24: v_ch = "F";
            8'd25: v_ch = "G";
            8'd31: v_ch = "H";
            8'd32: v_ch = "K";
            8'd33: v_ch = "M";
            8'd34: v_ch = "O";
            8'd35: v_ch = "P";
            8'd41: v_ch = "Q";
            8'd42: v_ch = "R";
            8'd43: v_ch = "S";
            8'd44: v_ch = "T";
            8'd45: v_ch = "U";
            8'd51: v_ch = "V";
            8'd52: v_ch = "W";
            8'd53: v_ch = "X";
            8'd54: v_ch = "Y";
            8'd55: v_ch = "Z";
            default: v_ch = 8'h3F;
        endcase
        return v_ch;
    endfunction

    function automatic logic [7:0] f_decode(input logic [7:0] i_cipher, input logic [7:0] i_code);
        logic [7:0] v_diff;
        v_diff = i_cipher - i_code;
        if ((i_code == 8'd0) || (i_cipher < i_code)) begin
            return 8'h3F;
        end
        return f_symbol(v_diff);
    endfunction

    logic [p_cipher_length*8-1:0] w_text;

    for (genvar g = 0; g < p_cipher_length; g++) begin : g_char
        localparam int lp_key = g % p_secret_length;
        logic [7:0] w_key_code;
        assign w_key_code = f_key_code(i_w_secret[(p_secret_length-1-lp_key)*8 +: 8]);
        assign w_text[(p_cipher_length-1-g)*8 +: 8] =
            f_decode(i_w_cipher[(p_cipher_length-1-g)*8 +: 8], w_key_code);
    end

    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            o_r_text  <= '0;
            o_r_valid <= 1'b0;
        end else begin
            o_r_valid <= i_w_valid;
            if (i_w_valid) begin
                o_r_text <= w_text;
            end
        end
    end

endmodule

// File: tb/tb_polybius_decrypt.sv
// Directed bench for polybius_decrypt: reset, nominal decode, invalid digits, underflow, bad key, J key, streaming.
module tb_polybius_decrypt;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic [215:0] cipher;
    logic [47:0]  secret;
    logic [215:0] text;
    logic         text_vld;

    int n_cmp;
    int n_err;

    logic [215:0] c_nominal;
    logic [215:0] c_all18;
    logic [215:0] c_under;
    logic [215:0] c_jay;
    logic [215:0] e_nominal;
    logic [215:0] e_all18;
    logic [215:0] e_under;
    logic [215:0] e_allq;
    logic [215:0] e_jay;

    polybius_decrypt #(
        .p_cipher_length(27),
        .p_secret_length(6)
    ) dut (
        .i_w_clk   (clk),
        .i_w_rst_n (rst_n),
        .i_w_valid (valid),
        .i_w_cipher(cipher),
        .i_w_secret(secret),
        .o_r_text  (text),
        .o_r_valid (text_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        c_nominal = 216'h371B423A2D2E1736391D2A391825181D363920381C2323381A361C;
        c_all18   = {27{8'h18}};
        c_under   = {8'h05, c_nominal[207:0]};
        c_jay     = {8'h3A, 8'h1C, {25{8'h18}}};
        e_nominal = "TEXTFOARTELUNGDEMULTELITERE";
        e_all18   = "NAD??ANAD??ANAD??ANAD??ANAD";
        e_under   = "?EXTFOARTELUNGDEMULTELITERE";
        e_allq    = {27{8'h3F}};
        e_jay     = {"TI", {25{8'h3F}}};

        rst_n  = 1'b0;
        valid  = 1'b0;
        cipher = '0;
        secret = "DANILA";
        step();
        step();
        check("reset_text", text, '0);
        check("reset_vld", {215'd0, text_vld}, 216'd0);

        rst_n = 1'b1;
        step();
        check("idle_vld", {215'd0, text_vld}, 216'd0);

        // Nominal single pulse
        cipher = c_nominal;
        valid  = 1'b1;
        step();
        check("nominal_text", text, e_nominal);
        check("nominal_vld", {215'd0, text_vld}, 216'd1);
        valid  = 1'b0;
        cipher = c_all18;
        step();
        check("nominal_vld_drop", {215'd0, text_vld}, 216'd0);
        check("nominal_hold", text, e_nominal);

        // Invalid digits and key wrap
        valid = 1'b1;
        step();
        check("all18_text", text, e_all18);

        cipher = c_under;
        step();
        check("underflow_text", text, e_under);

        secret = 48'h0;
        cipher = c_nominal;
        step();
        check("badkey_text", text, e_allq);

        secret = "JJJJJJ";
        cipher = c_jay;
        step();
        check("jkey_text", text, e_jay);

        // Reset beats a simultaneous capture
        secret = "DANILA";
        cipher = c_nominal;
        rst_n  = 1'b0;
        step();
        check("rst_valid_text", text, '0);
        check("rst_valid_vld", {215'd0, text_vld}, 216'd0);

        rst_n = 1'b1;
        valid = 1'b0;
        step();
        check("post_rst_idle", text, '0);
        valid = 1'b1;
        step();
        check("post_rst_text", text, e_nominal);
        check("post_rst_vld", {215'd0, text_vld}, 216'd1);

        // Streaming alternation
        cipher = c_all18;
        step();
        check("stream1_text", text, e_all18);
        check("stream1_vld", {215'd0, text_vld}, 216'd1);
        cipher = c_nominal;
        step();
        check("stream2_text", text, e_nominal);
        check("stream2_vld", {215'd0, text_vld}, 216'd1);
        cipher = c_all18;
        step();
        check("stream3_text", text, e_all18);
        check("stream3_vld", {215'd0, text_vld}, 216'd1);
        valid = 1'b0;
        step();
        check("stream_end_vld", {215'd0, text_vld}, 216'd0);
        check("stream_end_hold", text, e_all18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
